crossbar_scheduler: RTL and testbench

CROSSBAR_SCHEDULER -- requirements
Module: crossbar_scheduler

---
 rtl/crossbar_scheduler_if.sv | 19 +
 rtl/crossbar_scheduler.sv | 101 ++++++++++
 tb/tb_crossbar_scheduler.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/crossbar_scheduler_if.sv
// crossbar_scheduler_if: input FIFO, output mux and output RAM signals of the 3x3 crossbar
interface crossbar_scheduler_if;
  logic fifo_empty1, fifo_empty2, fifo_empty3;
  logic [31:0] fifo_out1, fifo_out2, fifo_out3;
  logic fifo_rd1, fifo_rd2, fifo_rd3;
  logic [1:0] mux_sel1, mux_sel2, mux_sel3;
  logic out_ram_wr1, out_ram_wr2, out_ram_wr3;
  logic pkt_done1, pkt_done2, pkt_done3;
  modport master (
    output fifo_empty1, fifo_empty2, fifo_empty3, fifo_out1, fifo_out2, fifo_out3,
    input fifo_rd1, fifo_rd2, fifo_rd3, mux_sel1, mux_sel2, mux_sel3,
    input out_ram_wr1, out_ram_wr2, out_ram_wr3, pkt_done1, pkt_done2, pkt_done3
  );
  modport slave (
    input fifo_empty1, fifo_empty2, fifo_empty3, fifo_out1, fifo_out2, fifo_out3,
    output fifo_rd1, fifo_rd2, fifo_rd3, mux_sel1, mux_sel2, mux_sel3,
    output out_ram_wr1, out_ram_wr2, out_ram_wr3, pkt_done1, pkt_done2, pkt_done3
  );
endinterface

// File: rtl/crossbar_scheduler.sv
// crossbar_scheduler: 3x3 packet crossbar with per-input FSMs and per-output round-robin arbiters
module crossbar_scheduler #(
  parameter int LEN_W = 8
) (
  input logic clk,
  input logic reset,
  crossbar_scheduler_if.slave bus
);
  typedef enum logic [2:0] {IDLE, HDR, REQ, XFER, DRAIN, DROP} state_t;
  state_t state [1:3];
  logic [1:0] dest [1:3];
  logic [LEN_W-1:0] cnt [1:3];
  logic [1:0] hd [1:3];
  logic [LEN_W-1:0] hl [1:3];
  logic [1:0] last [1:3];
  logic [1:0] sel [1:3];
  logic [1:0] gnt [0:3];
  logic [3:1] empty, rd, wr, wr_nxt, done;

  function automatic logic [1:0] rr(logic [1:0] l, int k);
    return 2'((int'(l) + k - 1) % 3 + 1);
  endfunction

  assign empty = {bus.fifo_empty3, bus.fifo_empty2, bus.fifo_empty1};
  assign hd[1] = bus.fifo_out1[31:30];
  assign hd[2] = bus.fifo_out2[31:30];
  assign hd[3] = bus.fifo_out3[31:30];
  assign hl[1] = bus.fifo_out1[LEN_W-1:0];
  assign hl[2] = bus.fifo_out2[LEN_W-1:0];
  assign hl[3] = bus.fifo_out3[LEN_W-1:0];

  always_comb begin
    rd = '0;
    for (int i = 1; i <= 3; i++)
      rd[i] = !reset && !empty[i] && (state[i] == IDLE || ((state[i] == XFER || state[i] == DROP) && cnt[i] != '0));
  end

  // an output is owned while some input sits in XFER/DRAIN for it; owned outputs grant nothing
  always_comb begin
    gnt[0] = 2'd0;
    sel = '{default: 2'd0};
    done = '0;
    wr_nxt = '0;
    for (int o = 1; o <= 3; o++) begin
      gnt[o] = 2'd0;
      for (int i = 1; i <= 3; i++)
        if ((state[i] == XFER || state[i] == DRAIN) && dest[i] == 2'(o)) begin
          sel[o] = 2'(i);
          done[o] = state[i] == DRAIN;
          wr_nxt[o] = rd[i];
        end
      for (int k = 1; k <= 3; k++)
        if (sel[o] == 2'd0 && gnt[o] == 2'd0 && state[rr(last[o], k)] == REQ && dest[rr(last[o], k)] == 2'(o))
          gnt[o] = rr(last[o], k);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i <= 3; i++) begin
        state[i] <= IDLE;
        dest[i] <= 2'd0;
        cnt[i] <= '0;
        last[i] <= 2'd3;
        wr[i] <= 1'b0;
      end
    end else begin
      for (int i = 1; i <= 3; i++) begin
        wr[i] <= wr_nxt[i];
        if (gnt[i] != 2'd0) last[i] <= gnt[i];
        case (state[i])
          IDLE: if (rd[i]) state[i] <= HDR;
          HDR: begin
            dest[i] <= hd[i];
            cnt[i] <= hl[i];
            state[i] <= hd[i] != 2'd0 ? REQ : hl[i] != '0 ? DROP : IDLE;
          end
          REQ: if (gnt[dest[i]] == 2'(i)) state[i] <= cnt[i] != '0 ? XFER : DRAIN;
          XFER, DROP: if (rd[i]) begin
            cnt[i] <= cnt[i] - LEN_W'(1);
            if (cnt[i] == LEN_W'(1)) state[i] <= state[i] == XFER ? DRAIN : IDLE;
          end
          default: state[i] <= IDLE;
        endcase
      end
    end
  end

  assign bus.fifo_rd1 = rd[1];
  assign bus.fifo_rd2 = rd[2];
  assign bus.fifo_rd3 = rd[3];
  assign bus.mux_sel1 = reset ? 2'd0 : sel[1];
  assign bus.mux_sel2 = reset ? 2'd0 : sel[2];
  assign bus.mux_sel3 = reset ? 2'd0 : sel[3];
  assign bus.out_ram_wr1 = wr[1] && !reset;
  assign bus.out_ram_wr2 = wr[2] && !reset;
  assign bus.out_ram_wr3 = wr[3] && !reset;
  assign bus.pkt_done1 = done[1] && !reset;
  assign bus.pkt_done2 = done[2] && !reset;
  assign bus.pkt_done3 = done[3] && !reset;
endmodule

// File: tb/tb_crossbar_scheduler.sv
// tb_crossbar_scheduler: FIFO models, per-input expected-delivery scoreboard and output monitor
module tb_crossbar_scheduler;
  typedef struct packed {logic [1:0] dest; logic done; logic [31:0] word;} ent_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  logic [31:0] fq [1:3][$];
  ent_t exp_q [1:3][$];
  int own [1:3][$];
  int own_c [1:3][$];
  logic [3:1] hold = '0;
  logic [3:1] prev_wr = '0;
  int wr_cnt [1:3];
  int wr_start [1:3];
  int done_cyc [1:3];

  crossbar_scheduler_if b();
  crossbar_scheduler #(.LEN_W(8)) dut (.clk(clk), .reset(reset), .bus(b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:1] rd_v();
    return {b.fifo_rd3, b.fifo_rd2, b.fifo_rd1};
  endfunction
  function automatic logic [1:0] sel_o(int o);
    return o == 1 ? b.mux_sel1 : o == 2 ? b.mux_sel2 : b.mux_sel3;
  endfunction
  function automatic logic wr_o(int o);
    return o == 1 ? b.out_ram_wr1 : o == 2 ? b.out_ram_wr2 : b.out_ram_wr3;
  endfunction
  function automatic logic done_o(int o);
    return o == 1 ? b.pkt_done1 : o == 2 ? b.pkt_done2 : b.pkt_done3;
  endfunction
  function automatic logic [31:0] q_i(int i);
    return i == 1 ? b.fifo_out1 : i == 2 ? b.fifo_out2 : b.fifo_out3;
  endfunction
  function automatic logic [14:0] all_outs();
    return {rd_v(), b.out_ram_wr3, b.out_ram_wr2, b.out_ram_wr1, b.pkt_done3, b.pkt_done2, b.pkt_done1,
            b.mux_sel1, b.mux_sel2, b.mux_sel3};
  endfunction

  task automatic chk(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic upd();
    b.fifo_empty1 = fq[1].size() == 0 || hold[1];
    b.fifo_empty2 = fq[2].size() == 0 || hold[2];
    b.fifo_empty3 = fq[3].size() == 0 || hold[3];
  endtask

  task automatic set_q(int i, logic [31:0] v);
    if (i == 1) b.fifo_out1 = v;
    else if (i == 2) b.fifo_out2 = v;
    else b.fifo_out3 = v;
  endtask

  // normal-mode FIFO: a request seen before the edge presents its word just after it
  task automatic cycle(output logic [3:1] r, output int c);
    @(negedge clk);
    r = rd_v();
    c = cyc;
    @(posedge clk);
    #1;
    for (int i = 1; i <= 3; i++)
      if (r[i]) begin
        chk("fifo_read_nonempty", fq[i].size() != 0, 1);
        if (fq[i].size() != 0) set_q(i, fq[i].pop_front());
      end
    upd();
  endtask

  task automatic ticks(int n);
    logic [3:1] r;
    int c;
    repeat (n) cycle(r, c);
  endtask

  task automatic send(int i, logic [1:0] d, int len, bit junk);
    logic [31:0] w;
    fq[i].push_back({d, junk ? 22'($urandom) : 22'd0, 8'(len)});
    for (int k = 0; k < len; k++) begin
      w = $urandom;
      fq[i].push_back(w);
      if (d != 2'd0) exp_q[i].push_back('{dest: d, done: 1'b0, word: w});
    end
    if (d != 2'd0) exp_q[i].push_back('{dest: d, done: 1'b1, word: 32'd0});
    upd();
  endtask

  task automatic drain(int max);
    int n = 0;
    while (fq[1].size() + fq[2].size() + fq[3].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size() != 0
           && n < max) begin
      ticks(1);
      n++;
    end
    chk("drain_in_time", n < max, 1);
    ticks(4);
  endtask

  task automatic wait_rd(int i, output int h);
    logic [3:1] r;
    int c;
    h = -1;
    for (int k = 0; k < 20 && h < 0; k++) begin
      cycle(r, c);
      if (r[i]) h = c;
    end
    chk("hdr_read_seen", h >= 0, 1);
  endtask

  task automatic clear_own();
    for (int o = 1; o <= 3; o++) begin
      own[o].delete();
      own_c[o].delete();
    end
  endtask

  task automatic contend(int first, int second);
    send(1, 2'd1, 2, 1'b1);
    send(3, 2'd1, 2, 1'b1);
    drain(200);
    chk("cont_count", own[1].size(), 2);
    if (own[1].size() == 2) begin
      chk("cont_first", own[1][0], first);
      chk("cont_second", own[1][1], second);
      chk("cont_gap", own_c[1][1] - own_c[1][0], 4);
    end
    clear_own();
  endtask

  // monitor: every write/done at output o is matched against the owner input's expected stream
  initial begin
    logic [1:0] s;
    logic avail;
    logic [31:0] d;
    ent_t e;
    forever begin
      @(negedge clk);
      for (int o = 1; o <= 3; o++) begin
        s = sel_o(o);
        if (wr_o(o)) begin
          wr_cnt[o]++;
          if (!prev_wr[o]) wr_start[o] = cyc;
          d = s == 2'd0 ? 32'd0 : q_i(int'(s));
          avail = s != 2'd0 && exp_q[s].size() != 0;
          chk("write_has_owner", avail, 1);
          if (avail) begin
            e = exp_q[s].pop_front();
            chk("write_word", {e.done, e.dest, e.word}, {1'b0, 2'(o), d});
          end
        end
        prev_wr[o] = wr_o(o);
        if (done_o(o)) begin
          done_cyc[o] = cyc;
          own[o].push_back(int'(s));
          own_c[o].push_back(cyc);
          avail = s != 2'd0 && exp_q[s].size() != 0;
          chk("done_has_owner", avail, 1);
          if (avail) begin
            e = exp_q[s].pop_front();
            chk("pkt_done", {e.done, e.dest}, {1'b1, 2'(o)});
          end
        end
      end
    end
  end

  initial begin
    logic [3:1] r;
    int c, h, base;
    logic [31:0] w;
    b.fifo_out1 = '0;
    b.fifo_out2 = '0;
    b.fifo_out3 = '0;
    upd();
    ticks(2);
    chk("reset_outs", all_outs(), 0);
    reset = 1'b0;
    ticks(1);
    chk("idle_outs", all_outs(), 0);

    send(1, 2'd2, 3, 1'b0);
    wait_rd(1, h);
    drain(100);
    chk("single_first_wr", wr_start[2] - h, 4);
    chk("single_done", done_cyc[2] - h, 6);
    chk("single_wr_cnt", wr_cnt[2], 3);
    chk("single_owner", own[2].size() == 1 ? own[2][0] : -1, 1);
    clear_own();

    contend(1, 3);
    contend(1, 3);

    send(1, 2'd3, 3, 1'b1);
    send(2, 2'd1, 3, 1'b1);
    drain(100);
    chk("par_same_start", wr_start[3] - wr_start[1], 0);
    chk("par_same_done", done_cyc[3] - done_cyc[1], 0);
    chk("par_owner3", own[3].size() == 1 ? own[3][0] : -1, 1);
    chk("par_owner1", own[1].size() == 1 ? own[1][0] : -1, 2);
    clear_own();
    contend(3, 1);

    base = wr_cnt[1] + wr_cnt[2] + wr_cnt[3];
    send(2, 2'd0, 2, 1'b0);
    drain(100);
    chk("drop_no_write", wr_cnt[1] + wr_cnt[2] + wr_cnt[3] - base, 0);
    chk("drop_no_done", own[1].size() + own[2].size() + own[3].size(), 0);
    send(1, 2'd1, 0, 1'b0);
    wait_rd(1, h);
    drain(100);
    chk("zero_done", done_cyc[1] - h, 3);
    chk("zero_no_write", wr_cnt[1] + wr_cnt[2] + wr_cnt[3] - base, 0);
    chk("zero_done_count", own[1].size(), 1);
    clear_own();

    base = wr_cnt[3];
    w = $urandom;
    fq[2].push_back(32'hC000_0004);
    fq[2].push_back(w);
    exp_q[2].push_back('{dest: 2'd3, done: 1'b0, word: w});
    upd();
    ticks(10);
    chk("under_one_write", wr_cnt[3] - base, 1);
    chk("under_sel_hold", b.mux_sel3, 2);
    w = $urandom;
    fq[2].push_back(w);
    exp_q[2].push_back('{dest: 2'd3, done: 1'b0, word: w});
    upd();
    ticks(3);
    chk("under_resume", wr_cnt[3] - base, 2);
    chk("under_sel_hold2", b.mux_sel3, 2);
    reset = 1'b1;
    fq[2].push_back($urandom);
    for (int i = 1; i <= 3; i++) exp_q[i].delete();
    upd();
    cycle(r, c);
    chk("reset_rd_forced", r, 0);
    chk("reset_mid_outs", all_outs(), 0);
    for (int i = 1; i <= 3; i++) fq[i].delete();
    upd();
    reset = 1'b0;
    chk("post_reset_outs", all_outs(), 0);
    ticks(5);
    chk("post_reset_no_write", wr_cnt[3] - base, 2);
    chk("post_reset_no_done", own[3].size(), 0);
    clear_own();

    for (int p = 0; p < 60; p++) begin
      send($urandom_range(1, 3), 2'($urandom), $urandom_range(0, 5), 1'b1);
      repeat ($urandom_range(0, 6)) begin
        hold = 3'($urandom) & 3'($urandom);
        upd();
        ticks(1);
      end
    end
    hold = '0;
    upd();
    drain(5000);
    chk("final_scoreboard_empty", exp_q[1].size() + exp_q[2].size() + exp_q[3].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
